// File: rtl/dsc_img_pkg.sv
// Shared types and constants for the Roberts-cross window generator.
package dsc_img_pkg;

  // Controller states: take pixels, wait on the core, present its result.
  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_RUN    = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  localparam int unsigned DEF_IMG_WIDTH  = 8;
  localparam int unsigned DEF_IMG_HEIGHT = 8;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsc_roberts_window_gen_if.sv
// Pixel stream, core handshake and result signals of the window generator.
interface dsc_roberts_window_gen_if #(
  parameter int unsigned DATA_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] win00;
  logic [DATA_WIDTH-1:0] win01;
  logic [DATA_WIDTH-1:0] win10;
  logic [DATA_WIDTH-1:0] win11;
  logic                  core_en;
  logic                  core_done;
  logic [DATA_WIDTH-1:0] core_result;
  logic [DATA_WIDTH-1:0] res_out;
  logic                  res_valid;
  logic                  frame_done;

  // Environment side: pixel source, Roberts core and result sink.
  modport master (
    output pix_in, pix_valid, core_done, core_result,
    input  pix_ready, win00, win01, win10, win11, core_en,
           res_out, res_valid, frame_done
  );

  // Window generator side.
  modport slave (
    input  pix_in, pix_valid, core_done, core_result,
    output pix_ready, win00, win01, win10, win11, core_en,
           res_out, res_valid, frame_done
  );
endinterface

// File: rtl/dsc_line_buffer.sv
// One-row line buffer: single port, the read returns the value stored before
// a write to the same address takes effect.
module dsc_line_buffer #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the new row value; the asynchronous read below still sees the old one.
  // NOTE: storage arrays get no reset -- it would turn RAM into flops, and row-0
  // gating upstream keeps stale contents from ever reaching a window.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dsc_roberts_window_gen.sv
// Builds 2x2 raster windows from a pixel stream, hands each to a Roberts-cross
// core, and returns the core result with a per-frame completion pulse.
module dsc_roberts_window_gen
  import dsc_img_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input logic                     clk,
  input logic                     rst,
  dsc_roberts_window_gen_if.slave bus
);

  localparam int unsigned CW = cnt_width(IMG_WIDTH);
  localparam int unsigned RW = cnt_width(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t                state_q;
  state_t                state_d;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic [DATA_WIDTH-1:0] top;
  logic [DATA_WIDTH-1:0] top_prev_q;
  logic [DATA_WIDTH-1:0] cur_prev_q;
  logic [DATA_WIDTH-1:0] win00_q;
  logic [DATA_WIDTH-1:0] win01_q;
  logic [DATA_WIDTH-1:0] win10_q;
  logic [DATA_WIDTH-1:0] win11_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  last_q;
  logic                  ready;
  logic                  accept;
  logic                  win_fire;
  logic                  is_last;

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign ready    = (state_q == ST_ACCEPT) && !rst;
  assign accept   = bus.pix_valid && ready;
  // A window exists only once a full row above and a column to the left exist.
  assign win_fire = accept && (col_q != '0) && (row_q != '0);
  assign is_last  = (col_q == COL_LAST) && (row_q == ROW_LAST);

  dsc_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_WIDTH (CW)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (bus.pix_in),
    .rdata (top)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ACCEPT;
    else     state_q <= state_d;
  end

  // Next-state logic: issue a window, wait for the core, emit one cycle.
  // NOTE: the default at the top of the block keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCEPT: if (win_fire)      state_d = ST_RUN;
      ST_RUN:    if (bus.core_done) state_d = ST_EMIT;
      ST_EMIT:                      state_d = ST_ACCEPT;
      default:                      state_d = ST_ACCEPT;
    endcase
  end

  // Raster position of the next pixel; frames wrap back to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Column history, window capture and core result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_prev_q <= '0;
      cur_prev_q <= '0;
      win00_q    <= '0;
      win01_q    <= '0;
      win10_q    <= '0;
      win11_q    <= '0;
      res_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      if (accept) begin
        top_prev_q <= top;
        cur_prev_q <= bus.pix_in;
      end
      if (win_fire) begin
        win00_q <= top_prev_q;
        win01_q <= top;
        win10_q <= cur_prev_q;
        win11_q <= bus.pix_in;
        last_q  <= is_last;
      end
      if ((state_q == ST_RUN) && bus.core_done) res_q <= bus.core_result;
    end
  end

  assign bus.pix_ready  = ready;
  assign bus.win00      = win00_q;
  assign bus.win01      = win01_q;
  assign bus.win10      = win10_q;
  assign bus.win11      = win11_q;
  assign bus.core_en    = (state_q == ST_RUN);
  assign bus.res_out    = res_q;
  assign bus.res_valid  = (state_q == ST_EMIT);
  assign bus.frame_done = (state_q == ST_EMIT) && last_q;

endmodule

// File: tb/tb_dsc_roberts_window_gen.sv
// Directed bench for the Roberts window generator on a 3x3 image.
module tb_dsc_roberts_window_gen;

  localparam int DW = 5;
  localparam int W  = 3;
  localparam int H  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsc_roberts_window_gen_if #(.DATA_WIDTH(DW)) bus ();

  dsc_roberts_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Core model: done after lat cycles of core_en, result = win00 + win11 mod 32.
  int   lat        = 4;
  int   core_cnt   = 0;
  logic force_done = 1'b0;
  always @(posedge clk) core_cnt <= bus.core_en ? core_cnt + 1 : 0;
  assign bus.core_done   = (bus.core_en && (core_cnt == lat - 1)) || force_done;
  assign bus.core_result = bus.win00 + bus.win11;

  // Observation logs, sampled on the falling edge.
  logic [4*DW-1:0] win_q [$];
  logic [DW:0]     res_q [$];
  int              en_runs [$];
  int              busy_runs [$];
  int              stab_err = 0;
  int              stray_fd = 0;
  int              en_len   = 0;
  int              busy_len = 0;
  logic [4*DW-1:0] cur_win  = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.core_en) begin
        if (en_len == 0) begin
          cur_win = {bus.win00, bus.win01, bus.win10, bus.win11};
          win_q.push_back(cur_win);
        end else if ({bus.win00, bus.win01, bus.win10, bus.win11} !== cur_win) begin
          stab_err++;
        end
        en_len++;
      end else if (en_len != 0) begin
        en_runs.push_back(en_len);
        en_len = 0;
      end
      if (!bus.pix_ready) busy_len++;
      else if (busy_len != 0) begin
        busy_runs.push_back(busy_len);
        busy_len = 0;
      end
      if (bus.res_valid) res_q.push_back({bus.frame_done, bus.res_out});
      else if (bus.frame_done) stray_fd++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    win_q.delete();
    res_q.delete();
    en_runs.delete();
    busy_runs.delete();
    stab_err = 0;
    stray_fd = 0;
  endtask

  // Present one pixel and return just after the edge that accepts it.
  task automatic send_pixel(input logic [DW-1:0] v, input bit keep_valid);
    int budget = 200;
    bus.pix_in    = v;
    bus.pix_valid = 1'b1;
    while (!bus.pix_ready && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (!bus.pix_ready) begin
      errors++;
      $display("FAIL send_timeout pixel %0d pix_ready got 0, required 1", v);
    end else begin
      tick();
    end
    if (!keep_valid) bus.pix_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int budget = 400;
    while (res_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (res_q.size() < n) begin
      errors++;
      $display("FAIL result_timeout results got %0d, required %0d", res_q.size(), n);
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready got %b expected 0", bus.pix_ready); end
    checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en got %b expected 0", bus.core_en); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b expected 0", bus.res_valid); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b expected 0", bus.frame_done); end
    checks++; if (bus.res_out !== 5'd0) begin errors++; $display("FAIL rst_res_out got %0d expected 0", bus.res_out); end
    checks++;
    if ({bus.win00, bus.win01, bus.win10, bus.win11} !== 20'd0) begin
      errors++;
      $display("FAIL rst_win got %h expected 0", {bus.win00, bus.win01, bus.win10, bus.win11});
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b expected 1", bus.pix_ready); end
    repeat (2) tick();
    clear_logs();
  endtask

  // V1: one frame 1..9 with idle gaps between pixels.
  task automatic test_frame();
    logic [4*DW-1:0] ew [4];
    logic [DW:0]     er [4];
    ew = '{{5'd1, 5'd2, 5'd4, 5'd5}, {5'd2, 5'd3, 5'd5, 5'd6},
           {5'd4, 5'd5, 5'd7, 5'd8}, {5'd5, 5'd6, 5'd8, 5'd9}};
    er = '{{1'b0, 5'd6}, {1'b0, 5'd8}, {1'b0, 5'd12}, {1'b1, 5'd14}};
    clear_logs();
    lat = 4;
    for (int v = 1; v <= 9; v++) begin
      send_pixel(DW'(v), 1'b0);
      tick();
    end
    wait_results(4);
    checks++; if (win_q.size() != 4) begin errors++; $display("FAIL v1_win_count got %0d expected 4", win_q.size()); end
    checks++; if (res_q.size() != 4) begin errors++; $display("FAIL v1_res_count got %0d expected 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (win_q[i] !== ew[i]) begin errors++; $display("FAIL v1_win[%0d] got %h expected %h", i, win_q[i], ew[i]); end
      checks++; if (res_q[i] !== er[i]) begin errors++; $display("FAIL v1_res[%0d] got %h expected %h", i, res_q[i], er[i]); end
      checks++; if (en_runs[i] !== 4) begin errors++; $display("FAIL v1_core_en_len[%0d] got %0d expected 4", i, en_runs[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL v1_win_stable got %0d changes expected 0", stab_err); end
    checks++; if (stray_fd != 0) begin errors++; $display("FAIL v1_stray_frame_done got %0d expected 0", stray_fd); end
  endtask

  // V5: core_done while idle must be ignored.
  task automatic test_spurious_done();
    clear_logs();
    force_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pix_ready !== 1'b1) begin errors++; $display("FAIL v5_ready[%0d] got %b expected 1", i, bus.pix_ready); end
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL v5_res_valid[%0d] got %b expected 0", i, bus.res_valid); end
    end
    force_done = 1'b0;
    tick();
    checks++; if (bus.res_out !== 5'd14) begin errors++; $display("FAIL v5_res_out got %0d expected 14", bus.res_out); end
    checks++; if (res_q.size() != 0) begin errors++; $display("FAIL v5_res_count got %0d expected 0", res_q.size()); end
  endtask

  // V2: pix_valid held high; back-pressure covers RUN plus EMIT.
  task automatic test_back_pressure();
    logic [DW:0] er [4];
    er = '{{1'b0, 5'd6}, {1'b0, 5'd8}, {1'b0, 5'd12}, {1'b1, 5'd14}};
    clear_logs();
    lat = 4;
    for (int v = 1; v <= 9; v++) send_pixel(DW'(v), 1'b1);
    bus.pix_valid = 1'b0;
    wait_results(4);
    checks++; if (busy_runs.size() != 4) begin errors++; $display("FAIL v2_busy_count got %0d expected 4", busy_runs.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy_runs[i] !== 5) begin errors++; $display("FAIL v2_busy_len[%0d] got %0d expected 5", i, busy_runs[i]); end
      checks++; if (res_q[i] !== er[i]) begin errors++; $display("FAIL v2_res[%0d] got %h expected %h", i, res_q[i], er[i]); end
    end
    checks++; if (win_q[0] !== {5'd1, 5'd2, 5'd4, 5'd5}) begin errors++; $display("FAIL v2_win0 got %h expected %h", win_q[0], {5'd1, 5'd2, 5'd4, 5'd5}); end
  endtask

  // V3: two frames back to back, no window may straddle them.
  task automatic test_back_to_back();
    logic [4*DW-1:0] ew [8];
    logic [DW:0]     er [8];
    ew = '{{5'd1, 5'd2, 5'd4, 5'd5}, {5'd2, 5'd3, 5'd5, 5'd6},
           {5'd4, 5'd5, 5'd7, 5'd8}, {5'd5, 5'd6, 5'd8, 5'd9},
           {5'd10, 5'd11, 5'd13, 5'd14}, {5'd11, 5'd12, 5'd14, 5'd15},
           {5'd13, 5'd14, 5'd16, 5'd17}, {5'd14, 5'd15, 5'd17, 5'd18}};
    er = '{{1'b0, 5'd6}, {1'b0, 5'd8}, {1'b0, 5'd12}, {1'b1, 5'd14},
           {1'b0, 5'd24}, {1'b0, 5'd26}, {1'b0, 5'd30}, {1'b1, 5'd0}};
    clear_logs();
    lat = 4;
    for (int v = 1; v <= 18; v++) send_pixel(DW'(v), 1'b1);
    bus.pix_valid = 1'b0;
    wait_results(8);
    checks++; if (win_q.size() != 8) begin errors++; $display("FAIL v3_win_count got %0d expected 8", win_q.size()); end
    checks++; if (res_q.size() != 8) begin errors++; $display("FAIL v3_res_count got %0d expected 8", res_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (win_q[i] !== ew[i]) begin errors++; $display("FAIL v3_win[%0d] got %h expected %h", i, win_q[i], ew[i]); end
      checks++; if (res_q[i] !== er[i]) begin errors++; $display("FAIL v3_res[%0d] got %h expected %h", i, res_q[i], er[i]); end
    end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL v3_win_stable got %0d changes expected 0", stab_err); end
  endtask

  // V4: reset during the second RUN cycle of the first window, then replay.
  task automatic test_reset_in_run();
    logic [4*DW-1:0] ew [4];
    logic [DW:0]     er [4];
    ew = '{{5'd1, 5'd2, 5'd4, 5'd5}, {5'd2, 5'd3, 5'd5, 5'd6},
           {5'd4, 5'd5, 5'd7, 5'd8}, {5'd5, 5'd6, 5'd8, 5'd9}};
    er = '{{1'b0, 5'd6}, {1'b0, 5'd8}, {1'b0, 5'd12}, {1'b1, 5'd14}};
    clear_logs();
    lat = 4;
    for (int v = 1; v <= 5; v++) send_pixel(DW'(v), 1'b0);
    checks++; if (bus.core_en !== 1'b1) begin errors++; $display("FAIL v4_run1_core_en got %b expected 1", bus.core_en); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (bus.core_en !== 1'b0) begin errors++; $display("FAIL v4_core_en_drop got %b expected 0", bus.core_en); end
    checks++; if (bus.pix_ready !== 1'b0) begin errors++; $display("FAIL v4_ready_in_rst got %b expected 0", bus.pix_ready); end
    rst = 1'b0;
    repeat (8) tick();
    checks++; if (res_q.size() != 0) begin errors++; $display("FAIL v4_discard got %0d results expected 0", res_q.size()); end
    clear_logs();
    for (int v = 1; v <= 9; v++) send_pixel(DW'(v), 1'b1);
    bus.pix_valid = 1'b0;
    wait_results(4);
    checks++; if (res_q.size() != 4) begin errors++; $display("FAIL v4_res_count got %0d expected 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (win_q[i] !== ew[i]) begin errors++; $display("FAIL v4_win[%0d] got %h expected %h", i, win_q[i], ew[i]); end
      checks++; if (res_q[i] !== er[i]) begin errors++; $display("FAIL v4_res[%0d] got %h expected %h", i, res_q[i], er[i]); end
    end
  endtask

  // V6: single-cycle core.
  task automatic test_fast_core();
    logic [DW:0] er [4];
    er = '{{1'b0, 5'd6}, {1'b0, 5'd8}, {1'b0, 5'd12}, {1'b1, 5'd14}};
    clear_logs();
    lat = 1;
    for (int v = 1; v <= 9; v++) send_pixel(DW'(v), 1'b1);
    bus.pix_valid = 1'b0;
    wait_results(4);
    checks++; if (res_q.size() != 4) begin errors++; $display("FAIL v6_res_count got %0d expected 4", res_q.size()); end
    checks++; if (en_runs.size() != 4) begin errors++; $display("FAIL v6_en_count got %0d expected 4", en_runs.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (en_runs[i] !== 1) begin errors++; $display("FAIL v6_core_en_len[%0d] got %0d expected 1", i, en_runs[i]); end
      checks++; if (busy_runs[i] !== 2) begin errors++; $display("FAIL v6_busy_len[%0d] got %0d expected 2", i, busy_runs[i]); end
      checks++; if (res_q[i] !== er[i]) begin errors++; $display("FAIL v6_res[%0d] got %h expected %h", i, res_q[i], er[i]); end
    end
  endtask

  initial begin
    bus.pix_in    = '0;
    bus.pix_valid = 1'b0;
    test_reset();
    test_frame();
    test_spurious_done();
    test_back_pressure();
    test_back_to_back();
    test_reset_in_run();
    test_fast_core();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
